// File: rtl/pipeline_controller_if.sv
// Control/data bundle between the fetch/microcode side and pipeline_controller.
// The perf-counter outputs exist only when PIPELINE_CTRL_PERF_EN is defined.
interface pipeline_controller_if #(
  parameter int PC_WIDTH = 30,
  parameter int MC_WIDTH = 22,
  parameter int ID_WIDTH = 25,
  parameter int STAGES   = 4
);
  logic                         clk_enable;
  logic [MC_WIDTH-1:0]          microcode_s0;
  logic [ID_WIDTH-1:0]          instruction_data_si;
  logic [2:0]                   cmp_op_s0;
  logic                         mem_in_use_s1;
  logic                         jump_if_branch_s2;
  logic                         data_dep;
  logic [31:0]                  reg_out_a;
  logic [31:0]                  reg_out_b;
  logic [PC_WIDTH-1:0]          jmp_addr;
  logic [PC_WIDTH-1:0]          pc;
  logic [PC_WIDTH-1:0]          pc_s0;
  logic [PC_WIDTH-1:0]          ret_addr;
  logic [(STAGES-1)*MC_WIDTH-1:0] microcode_s;
  logic [STAGES*ID_WIDTH-1:0]   instruction_data_s;
  logic [STAGES-1:0]            valid_s;
  logic                         squash_s0;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0]                  perf_stall_cycles;
  logic [31:0]                  perf_redirects;
`endif

  // Upstream side: drives decoded control and operands, observes the pipeline.
  modport master (
    output clk_enable, microcode_s0, instruction_data_si, cmp_op_s0,
           mem_in_use_s1, jump_if_branch_s2, data_dep, reg_out_a, reg_out_b, jmp_addr,
    input  pc, pc_s0, ret_addr, microcode_s, instruction_data_s, valid_s, squash_s0
`ifdef PIPELINE_CTRL_PERF_EN
    , input perf_stall_cycles, perf_redirects
`endif
  );

  // Controller side.
  modport slave (
    input  clk_enable, microcode_s0, instruction_data_si, cmp_op_s0,
           mem_in_use_s1, jump_if_branch_s2, data_dep, reg_out_a, reg_out_b, jmp_addr,
    output pc, pc_s0, ret_addr, microcode_s, instruction_data_s, valid_s, squash_s0
`ifdef PIPELINE_CTRL_PERF_EN
    , output perf_stall_cycles, perf_redirects
`endif
  );
endinterface

// File: rtl/pipeline_controller.sv
// pipeline_controller: program counter, PC/microcode/instruction-data pipeline,
// branch compare/resolve and hazard squashing for an STAGES-deep pipeline.
// Optional macro PIPELINE_CTRL_PERF_EN adds saturating stall/redirect counters.
module pipeline_controller #(
  parameter int PC_WIDTH   = 30,
  parameter int MC_WIDTH   = 22,
  parameter int ID_WIDTH   = 25,
  parameter int STAGES     = 4,
  parameter int BR_SQUASH  = 4,
  parameter int DEP_SQUASH = 3,
  parameter int MEM_TAP    = 3,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst_n,
  pipeline_controller_if.slave bus
);
  localparam int BR_W  = (BR_SQUASH  > 1) ? $clog2(BR_SQUASH)  : 1;
  localparam int DEP_W = (DEP_SQUASH > 1) ? $clog2(DEP_SQUASH) : 1;
  localparam logic [BR_W-1:0]  BR_LOAD  = BR_W'(BR_SQUASH - 1);
  localparam logic [DEP_W-1:0] DEP_LOAD = DEP_W'(DEP_SQUASH - 1);

  // Branch condition evaluation; unused codes never take.
  function automatic logic cmp_eval(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    logic r;
    case (op)
      3'd0:    r = 1'b0;
      3'd1:    r = (a == b);
      3'd2:    r = (a != b);
      3'd3:    r = ($signed(a) <  $signed(b));
      3'd4:    r = ($signed(a) >= $signed(b));
      3'd5:    r = (a <  b);
      3'd6:    r = (a >= b);
      3'd7:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [PC_WIDTH-1:0] pc_r, pc_sf_r, pc_s0_r, pc_s1_r, pc_s2_r;
  logic                branch_r;
  logic [BR_W-1:0]     br_cnt_r;
  logic [DEP_W-1:0]    dep_cnt_r;
  logic [MEM_TAP-1:0]  mem_sr_r;
  logic [STAGES-1:0][ID_WIDTH-1:0] id_r;   // index 0 = s0
  logic [STAGES-2:0][MC_WIDTH-1:0] mc_r;   // index 0 = s1
  logic [STAGES-1:0]   valid_r;

  logic                branch_s;
  logic                taken_s;
  logic                squash_s;
  logic [PC_WIDTH-1:0] pc_next_s;

  // Compare, squash combine and next-PC selection (redirect > replay > hold > increment).
  always_comb begin
    branch_s  = cmp_eval(bus.cmp_op_s0, bus.reg_out_a, bus.reg_out_b);
    taken_s   = bus.jump_if_branch_s2 & branch_r;
    squash_s  = bus.data_dep | (dep_cnt_r != '0) | branch_r | (br_cnt_r != '0) |
                mem_sr_r[MEM_TAP-1];
    pc_next_s = pc_r;
    if (taken_s) begin
      pc_next_s = bus.jmp_addr;
    end else if (bus.data_dep) begin
      pc_next_s = pc_s1_r;
    end else if (bus.mem_in_use_s1) begin
      pc_next_s = pc_r;
    end else begin
      pc_next_s = pc_r + PC_WIDTH'(1);
    end
  end

  // PC chain, compare result and squash windows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r      <= RESET_PC;
      pc_sf_r   <= RESET_PC;
      pc_s0_r   <= RESET_PC;
      pc_s1_r   <= RESET_PC;
      pc_s2_r   <= RESET_PC;
      branch_r  <= 1'b0;
      br_cnt_r  <= '0;
      dep_cnt_r <= '0;
      mem_sr_r  <= '0;
    end else if (bus.clk_enable) begin
      pc_r      <= pc_next_s;
      pc_sf_r   <= pc_r;
      pc_s0_r   <= pc_sf_r;
      pc_s1_r   <= pc_s0_r;
      pc_s2_r   <= pc_s1_r;
      branch_r  <= branch_s;
      // A new event reloads the window rather than extending it.
      br_cnt_r  <= branch_r ? BR_LOAD :
                   ((br_cnt_r != '0) ? br_cnt_r - BR_W'(1) : '0);
      dep_cnt_r <= bus.data_dep ? DEP_LOAD :
                   ((dep_cnt_r != '0) ? dep_cnt_r - DEP_W'(1) : '0);
      mem_sr_r  <= MEM_TAP'({mem_sr_r, bus.mem_in_use_s1});
    end
  end

  // Stage payload: s0 capture, bubble insertion at s0->s1, plain delay beyond.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_r    <= '0;
      mc_r    <= '0;
      valid_r <= '0;
    end else if (bus.clk_enable) begin
      id_r[0]    <= bus.instruction_data_si;
      valid_r[0] <= 1'b1;
      id_r[1]    <= squash_s ? '0 : id_r[0];
      mc_r[0]    <= squash_s ? '0 : bus.microcode_s0;
      valid_r[1] <= ~squash_s & valid_r[0];
      for (int k = 2; k < STAGES; k++) begin
        id_r[k]    <= id_r[k-1];
        mc_r[k-1]  <= mc_r[k-2];
        valid_r[k] <= valid_r[k-1];
      end
    end
  end

  assign bus.pc                 = pc_r;
  assign bus.pc_s0              = pc_s0_r;
  assign bus.ret_addr           = pc_s2_r;
  assign bus.microcode_s        = mc_r;
  assign bus.instruction_data_s = id_r;
  assign bus.valid_s            = valid_r;
  assign bus.squash_s0          = squash_s;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] perf_stall_r;
  logic [31:0] perf_redir_r;

  // Saturating counts of blocked cycles and taken redirects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_r <= 32'd0;
      perf_redir_r <= 32'd0;
    end else if (bus.clk_enable) begin
      if (squash_s && (perf_stall_r != 32'hFFFF_FFFF)) perf_stall_r <= perf_stall_r + 32'd1;
      if (taken_s && (perf_redir_r != 32'hFFFF_FFFF))  perf_redir_r <= perf_redir_r + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = perf_stall_r;
  assign bus.perf_redirects    = perf_redir_r;
`endif
endmodule
